// File: rtl/main_ctr_fsm.sv
// Multi-cycle MIPS main controller: IF/ID/EX/MEM/WB/BR/JMP sequencing with ready-based memory handshake.
// Define MAINCTR_IMMLOGIC_EN to add andi/ori/slti on the addi path.
module main_ctr_fsm #(
  parameter int ALUOP_W  = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opCode,
  input  logic               memRdy,
  output logic               pcWr,
  output logic               B,
  output logic               J,
  output logic               irWr,
  output logic               regDst,
  output logic               M2R,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic               regWr,
  output logic               memRe,
  output logic               memWr,
  output logic               iord,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               illegalOp,
  output logic               busErr,
  output logic [2:0]         state
);

`ifdef MAINCTR_IMMLOGIC_EN
  localparam int ALUOP_MIN = 3;
`else
  localparam int ALUOP_MIN = 2;
`endif

  if (ALUOP_W < ALUOP_MIN) begin : g_aluop_w_chk
    $error("main_ctr_fsm: ALUOP_W too narrow for the enabled ALU operations");
  end
  if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_wait_max_chk
    $error("main_ctr_fsm: WAIT_MAX must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_BR  = 3'd5,
    S_JMP = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    K_R, K_LW, K_SW, K_ADDI, K_ANDI, K_ORI, K_SLTI, K_BEQ, K_J, K_ILL
  } op_kind_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [7:0] WAIT_LIM  = 8'(WAIT_MAX - 1);

  function automatic op_kind_t decode_op(input logic [5:0] op);
    case (op)
      6'b000000: return K_R;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b001000: return K_ADDI;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
`ifdef MAINCTR_IMMLOGIC_EN
      6'b001100: return K_ANDI;
      6'b001101: return K_ORI;
      6'b001010: return K_SLTI;
`endif
      default:   return K_ILL;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [7:0] wait_q, wait_d;
  logic [2:0] alu_c;
  op_kind_t   op_kind, id_kind;
  logic       timeout;

  assign op_kind = decode_op(op_q);
  assign id_kind = decode_op(opCode);
  // wait_q counts memRdy-low cycles already spent; this cycle would be number WAIT_MAX
  assign timeout = !memRdy && (wait_q == WAIT_LIM);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = '0;
    alu_c     = ALU_ADD;
    pcWr      = 1'b0;
    B         = 1'b0;
    J         = 1'b0;
    irWr      = 1'b0;
    regDst    = 1'b0;
    M2R       = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    regWr     = 1'b0;
    memRe     = 1'b0;
    memWr     = 1'b0;
    iord      = 1'b0;
    illegalOp = 1'b0;
    busErr    = 1'b0;
    case (state_q)
      S_IF: begin
        memRe   = 1'b1;
        aluSrcB = 2'b01;
        if (memRdy) begin
          irWr    = 1'b1;
          pcWr    = 1'b1;
          state_d = S_ID;
        end else if (timeout) begin
          busErr  = 1'b1;
          state_d = S_IF;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end
      S_ID: begin
        op_d    = opCode;
        aluSrcB = 2'b11;
        case (id_kind)
          K_BEQ:   state_d = S_BR;
          K_J:     state_d = S_JMP;
          K_ILL: begin
            illegalOp = 1'b1;
            state_d   = S_IF;
          end
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        case (op_kind)
          K_R: begin
            aluSrcB = 2'b00;
            alu_c   = ALU_FUNCT;
            state_d = S_WB;
          end
          K_LW, K_SW: state_d = S_MEM;
          K_ADDI:     state_d = S_WB;
          K_ANDI: begin alu_c = ALU_AND; state_d = S_WB; end
          K_ORI:  begin alu_c = ALU_OR;  state_d = S_WB; end
          K_SLTI: begin alu_c = ALU_SLT; state_d = S_WB; end
          default:    state_d = S_IF;
        endcase
      end
      S_MEM: begin
        iord  = 1'b1;
        memRe = (op_kind == K_LW);
        memWr = (op_kind == K_SW);
        if (memRdy) begin
          state_d = (op_kind == K_LW) ? S_WB : S_IF;
        end else if (timeout) begin
          busErr  = 1'b1;
          state_d = S_IF;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end
      S_WB: begin
        regWr   = 1'b1;
        regDst  = (op_kind == K_R);
        M2R     = (op_kind == K_LW);
        state_d = S_IF;
      end
      S_BR: begin
        aluSrcA = 1'b1;
        alu_c   = ALU_SUB;
        B       = 1'b1;
        state_d = S_IF;
      end
      S_JMP: begin
        J       = 1'b1;
        pcWr    = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
    ALUop = ALUOP_W'(alu_c);
    state = state_q;
    // reset silences every output immediately, including an in-flight memWr
    if (rst) begin
      pcWr = 1'b0; B = 1'b0; J = 1'b0; irWr = 1'b0; regDst = 1'b0; M2R = 1'b0;
      aluSrcA = 1'b0; aluSrcB = 2'b00; regWr = 1'b0; memRe = 1'b0; memWr = 1'b0;
      iord = 1'b0; ALUop = '0; illegalOp = 1'b0; busErr = 1'b0; state = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

endmodule
